// File: rtl/fifo_pack_pkg.sv
// Shared constants and helpers for the FIFO byte packer.
package fifo_pack_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_LANES = 4;

   // Width of a byte counter able to hold 0..lanes inclusive.
   function automatic int cnt_width(input int lanes);
      return $clog2(lanes + 1);
   endfunction

endpackage

// File: rtl/fifo_byte_packer_if.sv
// FIFO read port, flush request and packed-word output stream of the packer.
interface fifo_byte_packer_if
   import fifo_pack_pkg::*;
#(
   parameter int Width = DEF_WIDTH,
   parameter int Lanes = DEF_LANES
);
   localparam int CW = cnt_width(Lanes);

   logic                     fifo_empty;
   logic [Width-1:0]         fifo_data;
   logic                     fifo_r_en;
   logic                     flush;
   logic [Width*Lanes-1:0]   out_word;
   logic [CW-1:0]            out_bytes;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      input  fifo_empty, fifo_data, flush, out_ready,
      output fifo_r_en, out_word, out_bytes, out_valid
   );

   modport slave (
      output fifo_empty, fifo_data, flush, out_ready,
      input  fifo_r_en, out_word, out_bytes, out_valid
   );

endinterface

// File: rtl/fifo_byte_packer_lane_assembler.sv
// Assembly register: writes one byte into the addressed lane; clear zeroes every lane,
// so lanes not yet written always read as zero.
module lane_assembler
   import fifo_pack_pkg::*;
#(
   parameter int Width = DEF_WIDTH,
   parameter int Lanes = DEF_LANES
) (
   input  logic                          clk,
   input  logic                          wr,
   input  logic [cnt_width(Lanes)-1:0]   idx,
   input  logic [Width-1:0]              din,
   input  logic                          clr,
   output logic [Width*Lanes-1:0]        word
);
   localparam int CW = cnt_width(Lanes);

   // Lane storage: clear has priority, otherwise write the lane selected by idx
   always_ff @(posedge clk) begin
      if (clr) begin
         word <= {(Width*Lanes){1'b0}};
      end else if (wr) begin
         for (int i = 0; i < Lanes; i++) begin
            if (idx == CW'(i)) begin
               word[i*Width +: Width] <= din;
            end
         end
      end
   end

endmodule

// File: rtl/fifo_byte_packer.sv
// Drains a byte FIFO and packs Lanes consecutive bytes into one word on a
// valid/ready output; a flush request pushes out a partial word with its byte count.
module fifo_byte_packer
   import fifo_pack_pkg::*;
#(
   parameter int Width = DEF_WIDTH,
   parameter int Lanes = DEF_LANES
) (
   input  logic                clk,
   input  logic                rst,
   fifo_byte_packer_if.master  bus
);
   localparam int              CW      = cnt_width(Lanes);
   localparam int              WW      = Width * Lanes;
   localparam logic [CW:0]     LANES_W = (CW+1)'(Lanes);
   localparam logic [CW-1:0]   LANES_C = CW'(Lanes);

   logic [CW-1:0]  cnt;
   logic           pend;
   logic           flush_req;
   logic [WW-1:0]  word_q;
   logic [CW-1:0]  bytes_q;
   logic           valid_q;

   logic [CW:0]    fill;
   logic           r_en;
   logic           out_free;
   logic           full_xfer;
   logic           flush_xfer;
   logic           flush_done;
   logic           capture;
   logic           asm_clr;
   logic [WW-1:0]  asm_word;

   // Pop request and output-transfer decisions from the current state
   always_comb begin
      fill     = {1'b0, cnt} + {{CW{1'b0}}, pend};
      out_free = !valid_q || bus.out_ready;
      if (!rst && !bus.fifo_empty && !flush_req && (fill < LANES_W)) begin
         r_en = 1'b1;
      end else begin
         r_en = 1'b0;
      end
      // A full word always leaves before a pending flush is resolved.
      full_xfer = (cnt == LANES_C) && out_free;
      if (!full_xfer && flush_req && !pend) begin
         flush_done = (cnt == {CW{1'b0}}) || out_free;
         flush_xfer = (cnt != {CW{1'b0}}) && out_free;
      end else begin
         flush_done = 1'b0;
         flush_xfer = 1'b0;
      end
      capture = pend && !rst;
      asm_clr = rst || full_xfer || flush_xfer;
   end

   lane_assembler #(
      .Width (Width),
      .Lanes (Lanes)
   ) u_lanes (
      .clk  (clk),
      .wr   (capture),
      .idx  (cnt),
      .din  (bus.fifo_data),
      .clr  (asm_clr),
      .word (asm_word)
   );

   // Counters, flush latch and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= {CW{1'b0}};
         pend      <= 1'b0;
         flush_req <= 1'b0;
         word_q    <= {WW{1'b0}};
         bytes_q   <= {CW{1'b0}};
         valid_q   <= 1'b0;
      end else begin
         pend <= r_en;
         if (full_xfer || flush_xfer) begin
            word_q  <= asm_word;
            bytes_q <= cnt;
            valid_q <= 1'b1;
            cnt     <= {CW{1'b0}};
         end else begin
            if (valid_q && bus.out_ready) begin
               valid_q <= 1'b0;
            end
            if (pend) begin
               cnt <= cnt + CW'(1);
            end
         end
         if (flush_done) begin
            flush_req <= 1'b0;
         end else if (bus.flush) begin
            flush_req <= 1'b1;
         end
      end
   end

   assign bus.fifo_r_en = r_en;
   assign bus.out_word  = word_q;
   assign bus.out_bytes = bytes_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer with a behavioural 16-deep byte FIFO in front.
module tb_fifo_byte_packer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_byte_packer_if #(.Width(8), .Lanes(4)) bus ();

   fifo_byte_packer #(.Width(8), .Lanes(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Clock edge counter used for timing checks
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural FIFO: pop data appears on fifo_data in the cycle after the pop edge
   logic [7:0] mem [16];
   int         wp = 0;
   int         rp = 0;
   int         count = 0;
   logic       push = 1'b0;
   logic [7:0] push_data = 8'h00;

   assign bus.fifo_empty = (count == 0);

   always @(posedge clk) begin
      if (bus.fifo_r_en && (count != 0)) begin
         bus.fifo_data <= mem[rp];
         rp <= (rp + 1) % 16;
      end
      if (push && (count < 16)) begin
         mem[wp] <= push_data;
         wp <= (wp + 1) % 16;
      end
      count <= count + ((push && (count < 16)) ? 1 : 0)
                     - ((bus.fifo_r_en && (count != 0)) ? 1 : 0);
   end

   // Monitor: log accepted words and pops, sampled on the falling edge
   typedef struct {
      logic [31:0] w;
      logic [2:0]  b;
      int          c;
   } rec_t;
   rec_t wlog[$];
   int   plog[$];
   rec_t mon_rec;

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         mon_rec.w = bus.out_word;
         mon_rec.b = bus.out_bytes;
         mon_rec.c = cyc;
         wlog.push_back(mon_rec);
      end
      if (bus.fifo_r_en && !bus.fifo_empty) plog.push_back(cyc);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) step();
   endtask

   task automatic push_byte(input logic [7:0] b);
      push = 1'b1;
      push_data = b;
      step();
      push = 1'b0;
   endtask

   task automatic clear_logs();
      wlog.delete();
      plog.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cycles(3);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      n_cmp++;
      if (bus.out_word !== 32'h0) begin n_bad++; $display("FAIL reset_word: got %h want 00000000", bus.out_word); end
      n_cmp++;
      if (bus.out_bytes !== 3'd0) begin n_bad++; $display("FAIL reset_bytes: got %0d want 0", bus.out_bytes); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_word();
      clear_logs();
      push_byte(8'h00); push_byte(8'h02); push_byte(8'h04); push_byte(8'h06);
      wait_cycles(10);
      n_cmp++;
      if (wlog.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d words want 1", wlog.size()); end
      n_cmp++;
      if (wlog.size() < 1 || wlog[0].w !== 32'h06040200) begin
         n_bad++; $display("FAIL single_word: got %h want 06040200", (wlog.size() > 0) ? wlog[0].w : 32'hx);
      end
      n_cmp++;
      if (wlog.size() < 1 || wlog[0].b !== 3'd4) begin
         n_bad++; $display("FAIL single_bytes: got %0d want 4", (wlog.size() > 0) ? wlog[0].b : 3'hx);
      end
      n_cmp++;
      if (plog.size() !== 4) begin n_bad++; $display("FAIL single_pops: got %0d pops want 4", plog.size()); end
      n_cmp++;
      if (wlog.size() < 1 || plog.size() < 4 || (wlog[0].c - plog[3]) !== 3) begin
         n_bad++; $display("FAIL single_latency: got word/last-pop mismatch (words %0d pops %0d) want delta 3",
                           wlog.size(), plog.size());
      end
   endtask

   task automatic test_burst();
      logic [31:0] exp_w [4];
      exp_w[0] = 32'h06040200; exp_w[1] = 32'h0E0C0A08;
      exp_w[2] = 32'h16141210; exp_w[3] = 32'h1E1C1A18;
      clear_logs();
      for (int i = 0; i < 16; i++) push_byte(8'(2 * i));
      wait_cycles(20);
      n_cmp++;
      if (wlog.size() !== 4) begin n_bad++; $display("FAIL burst_count: got %0d words want 4", wlog.size()); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (wlog.size() <= i || wlog[i].w !== exp_w[i]) begin
            n_bad++; $display("FAIL burst_word%0d: got %h want %h", i, (wlog.size() > i) ? wlog[i].w : 32'hx, exp_w[i]);
         end
      end
      for (int i = 1; i < 4; i++) begin
         n_cmp++;
         if (wlog.size() <= i || (wlog[i].c - wlog[i-1].c) !== 6) begin
            n_bad++; $display("FAIL burst_spacing%0d: got %0d want 6", i,
                              (wlog.size() > i) ? (wlog[i].c - wlog[i-1].c) : -1);
         end
      end
      n_cmp++;
      if (count !== 0) begin n_bad++; $display("FAIL burst_fifo_empty: got %0d entries want 0", count); end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      clear_logs();
      for (int i = 0; i < 12; i++) push_byte(8'(2 * i));
      wait_cycles(20);
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", bus.out_valid); end
      n_cmp++;
      if (bus.out_word !== 32'h06040200) begin n_bad++; $display("FAIL bp_hold_word: got %h want 06040200", bus.out_word); end
      n_cmp++;
      if (count !== 4) begin n_bad++; $display("FAIL bp_fifo_left: got %0d want 4", count); end
      n_cmp++;
      if (bus.fifo_r_en !== 1'b0) begin n_bad++; $display("FAIL bp_r_en: got %b want 0", bus.fifo_r_en); end
      wait_cycles(3);
      n_cmp++;
      if (bus.out_word !== 32'h06040200) begin n_bad++; $display("FAIL bp_stable: got %h want 06040200", bus.out_word); end
      bus.out_ready = 1'b1;
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h0E0C0A08) begin
         n_bad++; $display("FAIL bp_same_edge: got valid %b word %h want 1 0E0C0A08", bus.out_valid, bus.out_word);
      end
      wait_cycles(15);
      n_cmp++;
      if (wlog.size() < 3 || wlog[1].w !== 32'h0E0C0A08 || wlog[2].w !== 32'h16141210) begin
         n_bad++; $display("FAIL bp_drain: got %0d words want 3 ending 0E0C0A08,16141210", wlog.size());
      end
      n_cmp++;
      if (wlog.size() < 2 || (wlog[1].c - wlog[0].c) !== 1) begin
         n_bad++; $display("FAIL bp_accept_gap: got %0d want 1", (wlog.size() > 1) ? (wlog[1].c - wlog[0].c) : -1);
      end
   endtask

   task automatic test_flush();
      clear_logs();
      push_byte(8'h10); push_byte(8'h12);
      wait_cycles(6);
      n_cmp++;
      if (wlog.size() !== 0) begin n_bad++; $display("FAIL flush_pre: got %0d words want 0", wlog.size()); end
      bus.flush = 1'b1; step(); bus.flush = 1'b0;
      wait_cycles(6);
      n_cmp++;
      if (wlog.size() !== 1 || wlog[0].w !== 32'h00001210 || wlog[0].b !== 3'd2) begin
         n_bad++; $display("FAIL flush_partial: got %0d words, first %h/%0d want 00001210/2",
                           wlog.size(), (wlog.size() > 0) ? wlog[0].w : 32'hx, (wlog.size() > 0) ? wlog[0].b : 3'hx);
      end
      bus.flush = 1'b1; step(); bus.flush = 1'b0;
      wait_cycles(6);
      n_cmp++;
      if (wlog.size() !== 1) begin n_bad++; $display("FAIL flush_empty: got %0d words want 1", wlog.size()); end
      push_byte(8'h20); push_byte(8'h22); push_byte(8'h24); push_byte(8'h26);
      wait_cycles(10);
      n_cmp++;
      if (wlog.size() !== 2 || wlog[1].w !== 32'h26242220 || wlog[1].b !== 3'd4) begin
         n_bad++; $display("FAIL flush_resume: got %0d words want 2 ending 26242220/4", wlog.size());
      end
   endtask

   task automatic test_empty_midword();
      clear_logs();
      push_byte(8'h31); push_byte(8'h33); push_byte(8'h35);
      wait_cycles(10);
      n_cmp++;
      if (wlog.size() !== 0 || bus.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL midword_hold: got %0d words valid %b want 0 0", wlog.size(), bus.out_valid);
      end
      push_byte(8'h37);
      wait_cycles(8);
      n_cmp++;
      if (wlog.size() !== 1 || wlog[0].w !== 32'h37353331 || wlog[0].b !== 3'd4) begin
         n_bad++; $display("FAIL midword_complete: got %0d words, first %h want 37353331/4",
                           wlog.size(), (wlog.size() > 0) ? wlog[0].w : 32'hx);
      end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      push_byte(8'h41); push_byte(8'h43);
      wait_cycles(5);
      rst = 1'b1;
      push = 1'b1; push_data = 8'h45;
      step();
      push = 1'b0;
      n_cmp++;
      if (bus.fifo_r_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_r_en: got %b want 0", bus.fifo_r_en); end
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_word !== 32'h0 || bus.out_bytes !== 3'd0) begin
         n_bad++; $display("FAIL rstmid_outputs: got %b/%h/%0d want 0/00000000/0", bus.out_valid, bus.out_word, bus.out_bytes);
      end
      rst = 1'b0;
      push_byte(8'h51); push_byte(8'h53); push_byte(8'h55);
      wait_cycles(10);
      n_cmp++;
      if (wlog.size() !== 1 || wlog[0].w !== 32'h55535145 || wlog[0].b !== 3'd4) begin
         n_bad++; $display("FAIL rstmid_clean: got %0d words, first %h want 55535145/4",
                           wlog.size(), (wlog.size() > 0) ? wlog[0].w : 32'hx);
      end
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_single_word();
      test_burst();
      test_backpressure();
      test_flush();
      test_empty_midword();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_byte_packer.md
# fifo_byte_packer

Downstream drain stage for the synchronous byte FIFO (8-bit, 16-deep, full/empty flags). It pops bytes from the FIFO with its `r_en`/`empty`/`data_out` interface and packs `Lanes` consecutive bytes into one wide word. Each word is presented on a valid/ready output. A flush request forces any partial word out, together with its byte count.

## Interface
- `Width`, default 8: byte width; must match the FIFO's `Width`.
- `Lanes`, default 4: bytes per output word; minimum 2.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_data`  in  Width: FIFO `data_out`.
- `fifo_r_en`  out  1: FIFO `r_en`; combinational.
- `flush`  in  1: one-cycle request to emit the partial word.
- `out_word`  out  Width*Lanes: packed word; lane 0 (first byte popped) in bits [Width-1:0].
- `out_bytes`  out  $clog2(Lanes+1): number of valid lanes in `out_word`.
- `out_valid`  out  1: `out_word`/`out_bytes` valid.
- `out_ready`  in  1: consumer accepts when `out_valid && out_ready` at a rising edge.

## Operation
- FIFO read contract:
  - A pop occurs at the rising edge where `fifo_r_en && !fifo_empty` is sampled.
  - The popped byte is on `fifo_data` throughout the following cycle.
- State:
  - `cnt` (0..Lanes): bytes held in the assembly register.
  - `pend` (1 bit): pop issued last cycle.
  - `flush_req` (1 bit): latched flush.
  - Output register: `out_word`, `out_bytes`, `out_valid`.
- `fifo_r_en = !rst && !fifo_empty && !flush_req && (cnt + pend < Lanes)`.
- Capture: if `pend`, write `fifo_data` into lane `cnt` and increment `cnt`.
  - Then `pend <= fifo_r_en && !fifo_empty`.
- Full-word transfer:
  - Condition: `cnt == Lanes` and the output register is free (`!out_valid || out_ready`).
  - Action: `out_word <= assembly`, `out_bytes <= Lanes`, `out_valid <= 1`, `cnt <= 0`.
- Flush:
  - `flush` sets `flush_req`; `flush` while `flush_req` is already set is ignored.
  - While `flush_req` is set, no new pops are issued; an in-flight pop (`pend`) is still captured.
  - When `pend == 0`:
    - `cnt == 0`: clear `flush_req`, emit nothing.
    - `cnt > 0` and output register free: transfer with `out_bytes <= cnt`; unused lanes zero; `cnt <= 0`; clear `flush_req`.
- Accept without a new transfer: `out_valid <= 0`.
- `out_word` and `out_bytes` hold stable while `out_valid && !out_ready`.
- Assembly register lanes at or above `cnt` read as zero.

## Timing
- Reset values: `cnt`, `pend`, `flush_req`, `out_valid`, `out_word`, `out_bytes` all 0; `fifo_r_en` forced 0 while `rst` is high.
- Latency: `out_valid` rises 2 cycles after the edge that pops the last byte of a word (one edge to capture, one to transfer).
- Sustained throughput with a non-empty FIFO and `out_ready` high: one word every `Lanes+2` cycles (6 cycles for `Lanes` = 4).
- Back-pressure:
  - With `cnt == Lanes` and `out_valid && !out_ready`, pops stop.
  - Transfer happens on the same edge the held word is accepted.
- FIFO empty mid-word: pops pause and the partial bytes are retained. No output until `Lanes` bytes arrive or a flush occurs.
- `flush` arriving in the same cycle as a full-word transfer: the full word goes out first. The flush then resolves as empty, with `cnt == 0`.
- Reset asserted mid-word or mid-handshake: the partial word and the pending output are discarded. A byte popped in the reset cycle is lost.

## Structure
- Shared package `fifo_pack_pkg`:
  - Default `Width`/`Lanes` constants.
  - A byte-count width function, `$clog2(Lanes+1)`.
- Sub-module `lane_assembler`: lane write decoder plus assembly register (`wr`, `idx`, `din`, `clr` → `word`).
- The top level holds the counters, the flush logic and the output register.

## Test plan
- Push 0x00, 0x02, 0x04, 0x06 into the FIFO, `out_ready` = 1 → one word 0x06040200 with `out_bytes` = 4; `fifo_r_en` low after the 4th pop until the transfer.
- Fill the FIFO with 16 bytes 0,2,…,30, `out_ready` = 1 → 4 words:
  - 0x06040200, 0x0E0C0A08, 0x16141210, 0x1E1C1A18.
  - Word spacing 6 cycles; FIFO empty at the end.
- Hold `out_ready` = 0 after the first word, with 8 bytes available:
  - The second word is assembled, then pops stop; the FIFO retains its remaining bytes.
  - `out_word` is stable at 0x06040200.
  - Release `out_ready` → the next word follows on the same edge.
- Push 0x10, 0x12, then pulse `flush` → `out_word` 0x00001210 with `out_bytes` = 2. `flush` with `cnt == 0` produces no output.
- Push 3 bytes and leave the FIFO empty → no `out_valid`. Push one more byte → the word completes with the correct lane order.
- Assert `rst` for 1 cycle after 2 bytes have been captured → all outputs 0. Then 4 new bytes produce a clean word with no stale lanes.
